// File: rtl/spi_dac_pkg.sv
// Shared constants and FSM encoding for the spi_dac serial DAC link.
package spi_dac_pkg;

  localparam int          FRAME_BITS  = 16;
  localparam int          DATA_MSB    = 11;
  localparam int          DATA_LSB    = 4;
  localparam logic [15:0] PAD_HI_MASK = 16'hF000;
  localparam logic [15:0] PAD_LO_MASK = 16'h000F;

  typedef enum logic [1:0] {ARM, IDLE, SHIFT, LONG} rx_state_e;

endpackage

// File: rtl/spi_dac_rx_if.sv
// Serial link inputs and status outputs of the spi_dac frame receiver.
interface spi_dac_rx_if #(parameter int CNT_W = 16);

  logic             din;
  logic             dsync_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             err_short;
  logic             err_long;
  logic             err_pad;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output din, dsync_n,
    input  rx_data, rx_valid, err_short, err_long, err_pad, frame_cnt, err_cnt
  );

  modport slave (
    input  din, dsync_n,
    output rx_data, rx_valid, err_short, err_long, err_pad, frame_cnt, err_cnt
  );

endinterface

// File: rtl/spi_dac_rx_sat_counter.sv
// Up-counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_dac_rx.sv
// Deserialises and checks 16-bit spi_dac frames; reports the DAC code and framing errors.
//   state | meaning
//   ARM   | after reset, discard any frame in flight until sync is seen high
//   IDLE  | between frames, waiting for sync low
//   SHIFT | collecting frame bits MSB first
//   LONG  | frame exceeded 16 bits, ignore bits until sync goes high
module spi_dac_rx
  import spi_dac_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  spi_dac_rx_if.slave  bus
);

  logic             din_r;
  logic             sync_r;
  logic             sync_vld;
  rx_state_e        state, state_n;
  logic [4:0]       bit_cnt, bit_cnt_n;
  logic [15:0]      shreg, shreg_n;
  logic             good_n, short_n, long_n, pad_n;
  logic [7:0]       rx_data;
  logic             rx_valid, err_short, err_long, err_pad;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  // sync_vld marks that sync_r holds a real sample rather than its reset value,
  // so ARM cannot mistake the reset value for an idle line mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_r    <= 1'b0;
      sync_r   <= 1'b1;
      sync_vld <= 1'b0;
    end else begin
      din_r    <= bus.din;
      sync_r   <= bus.dsync_n;
      sync_vld <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    good_n    = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
    pad_n     = 1'b0;
    case (state)
      ARM: begin
        if (sync_vld && sync_r) state_n = IDLE;
      end
      IDLE: begin
        if (!sync_r) begin
          state_n   = SHIFT;
          bit_cnt_n = 5'd1;
          shreg_n   = {shreg[14:0], din_r};
        end
      end
      SHIFT: begin
        if (sync_r) begin
          state_n = IDLE;
          if (bit_cnt < 5'(FRAME_BITS)) begin
            short_n = 1'b1;
          end else if ((shreg & (PAD_HI_MASK | PAD_LO_MASK)) != 16'h0000) begin
            pad_n = 1'b1;
          end else begin
            good_n = 1'b1;
          end
        end else if (bit_cnt == 5'(FRAME_BITS)) begin
          state_n = LONG;
        end else begin
          bit_cnt_n = bit_cnt + 5'd1;
          shreg_n   = {shreg[14:0], din_r};
        end
      end
      LONG: begin
        if (sync_r) begin
          state_n = IDLE;
          long_n  = 1'b1;
        end
      end
      default: state_n = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARM;
      bit_cnt   <= 5'd0;
      shreg     <= 16'h0000;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_pad   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      rx_valid  <= good_n;
      err_short <= short_n;
      err_long  <= long_n;
      err_pad   <= pad_n;
      if (good_n) begin
        rx_data   <= shreg[DATA_MSB:DATA_LSB];
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (short_n | long_n | pad_n),
    .clear (1'b0),
    .count (err_cnt)
  );

  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.err_short = err_short;
  assign bus.err_long  = err_long;
  assign bus.err_pad   = err_pad;
  assign bus.frame_cnt = frame_cnt;
  assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_spi_dac_rx.sv
// Scoreboard bench for spi_dac_rx: frames are classified by a length/content model at issue time.
module tb_spi_dac_rx;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [3:0] pulses;  // {rx_valid, err_short, err_long, err_pad}
    logic [7:0] data;
    int         fcnt;
    int         ecnt;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_dac_rx_if #(.CNT_W(CNT_W)) bus ();
  spi_dac_rx #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         m_fcnt = 0;
  int         m_ecnt = 0;
  logic [7:0] m_data = 8'h00;
  exp_t       q[$];
  bit         fbits[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    fbits.delete();
    for (int i = 15; i >= 0; i--) fbits.push_back(w[i]);
  endtask

  task automatic load_dac(input logic [7:0] d);
    load_word({4'h0, d, 4'h0});
  endtask

  task automatic load_rand(input int n);
    fbits.delete();
    for (int i = 0; i < n; i++) fbits.push_back(1'($urandom));
  endtask

  // Reference: a frame is judged only by how many low cycles it lasted and, if exactly 16, its word.
  task automatic predict(input int last_cyc);
    int          n;
    logic [15:0] w;
    exp_t        e;
    n = fbits.size();
    w = 16'h0000;
    if (n == 16) for (int i = 0; i < 16; i++) w = {w[14:0], fbits[i]};
    if (n > 16)                       e.pulses = 4'b0010;
    else if (n < 16)                  e.pulses = 4'b0100;
    else if ((w & 16'hF00F) != 16'h0) e.pulses = 4'b0001;
    else begin
      e.pulses = 4'b1000;
      m_data   = w[11:4];
      m_fcnt   = (m_fcnt + 1) % (CMAX + 1);
    end
    if (e.pulses != 4'b1000 && m_ecnt < CMAX) m_ecnt++;
    e.data = m_data;
    e.fcnt = m_fcnt;
    e.ecnt = m_ecnt;
    e.cyc  = last_cyc + 3;
    q.push_back(e);
  endtask

  task automatic drive_frame(input int gap);
    int last;
    last = 0;
    for (int i = 0; i < fbits.size(); i++) begin
      @(posedge clk); #1;
      bus.dsync_n = 1'b0;
      bus.din     = fbits[i];
      last        = cyc;
    end
    predict(last);
    repeat (gap) begin
      @(posedge clk); #1;
      bus.dsync_n = 1'b1;
      bus.din     = 1'($urandom);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 12 && q.size() != 0; k++) @(posedge clk);
    check(name, q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rx_data"},   int'(bus.rx_data), 0);
    check({tag, "_rx_valid"},  int'(bus.rx_valid), 0);
    check({tag, "_err_short"}, int'(bus.err_short), 0);
    check({tag, "_err_long"},  int'(bus.err_long), 0);
    check({tag, "_err_pad"},   int'(bus.err_pad), 0);
    check({tag, "_frame_cnt"}, int'(bus.frame_cnt), 0);
    check({tag, "_err_cnt"},   int'(bus.err_cnt), 0);
  endtask

  always @(negedge clk) begin
    logic [3:0] p;
    exp_t       e;
    if (!rst) begin
      p = {bus.rx_valid, bus.err_short, bus.err_long, bus.err_pad};
      if (p != 4'b0000) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", int'(p), 0);
        end else begin
          e = q.pop_front();
          check("pulses",    int'(p), int'(e.pulses));
          check("rx_data",   int'(bus.rx_data), int'(e.data));
          check("frame_cnt", int'(bus.frame_cnt), e.fcnt);
          check("err_cnt",   int'(bus.err_cnt), e.ecnt);
          check("latency",   cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          r;
    bus.din     = 1'b0;
    bus.dsync_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // loopback-style single frame
    load_dac(8'hA5); drive_frame(3);
    // four back-to-back frames, one high cycle between
    load_dac(8'h00); drive_frame(1);
    load_dac(8'hFF); drive_frame(1);
    load_dac(8'h3C); drive_frame(1);
    load_dac(8'hC3); drive_frame(3);
    // transmitter restart 8 bits in: 8 + 16 low cycles
    load_dac(8'h96);
    fbits = fbits[0:7];
    w = {4'h0, 8'h69, 4'h0};
    for (int i = 15; i >= 0; i--) fbits.push_back(w[i]);
    drive_frame(3);
    load_rand(10);   drive_frame(2);
    load_word(16'h1A50); drive_frame(2);
    wait_drain("drain_before_reset");

    // reset asserted at bit 6, released at bit 8 while the frame continues
    load_dac(8'h77);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.dsync_n = 1'b0;
      bus.din     = fbits[i];
      if (i == 6) begin
        #2 rst = 1'b1;
        #1 check_reset("midrst");
      end
      if (i == 8) #2 rst = 1'b0;
    end
    m_fcnt = 0; m_ecnt = 0; m_data = 8'h00;
    repeat (2) begin @(posedge clk); #1; bus.dsync_n = 1'b1; end
    load_dac(8'h5A); drive_frame(2);

    // saturate the 4-bit error counter
    for (int k = 0; k < 17; k++) begin
      load_rand(10); drive_frame(1);
    end
    load_dac(8'h11); drive_frame(2);

    // randomized mix
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5 || r == 9) begin
        load_dac(8'($urandom));
      end else if (r == 6) begin
        w = 16'($urandom);
        if ((w & 16'hF00F) == 16'h0) w[0] = 1'b1;
        load_word(w);
      end else if (r == 7) begin
        load_rand(int'($urandom_range(1, 15)));
      end else begin
        load_rand(int'($urandom_range(17, 30)));
      end
      drive_frame(int'($urandom_range(1, 3)));
    end
    wait_drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_dac_rx.md
# spi_dac_rx

Frame receiver for the 16-bit serial DAC link driven by `spi_dac`. It watches the `dout`/`dsync_n` pair in the same clock domain, deserialises each frame MSB-first, and checks its framing. It returns the 8-bit DAC code with a one-cycle valid pulse and counts good and bad frames. It serves as the on-chip loopback monitor and as the verification reference model for the DAC path.

## Interface
Parameters:
- `CNT_W`, default 16: width of the frame and error counters.

Ports:
- `clk`, in, 1: single system clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `din`, in, 1: serial data, i.e. `spi_dac.dout`.
- `dsync_n`, in, 1: frame sync, active low, i.e. `spi_dac.dsync_n`.
- `rx_data`, out, 8: last good DAC code, i.e. frame bits [11:4]. Holds until the next good frame.
- `rx_valid`, out, 1: one-cycle pulse; `rx_data` is new this cycle.
- `err_short`, out, 1: one-cycle pulse; the frame ended with fewer than 16 bits.
- `err_long`, out, 1: one-cycle pulse; the frame ran longer than 16 bits (transmitter restart).
- `err_pad`, out, 1: one-cycle pulse; 16 bits received but bits [15:12] or [3:0] are not zero.
- `frame_cnt`, out, CNT_W: good-frame count; wraps modulo 2^CNT_W.
- `err_cnt`, out, CNT_W: errored-frame count; saturates at all ones.

## Operation
- Input stage: `din` and `dsync_n` are each registered once into `din_r` and `sync_r`. The FSM uses only the registered copies.
- Frame definition: a maximal run of consecutive cycles with `sync_r` = 0. One bit is sampled per low cycle, MSB first, into a 16-bit shift register. A 5-bit counter `bit_cnt` tracks the bit count.
- FSM states:
  - ARM (reset state): waits for `sync_r` = 1, then goes to IDLE. A frame already in progress when reset releases is discarded silently, with no error and no count.
  - IDLE: `sync_r` = 0 → SHIFT. `bit_cnt` loads 1 and the first bit is shifted in.
  - SHIFT: `sync_r` = 0 and `bit_cnt` < 16 → shift, increment.
  - SHIFT: `sync_r` = 0 and `bit_cnt` = 16 → LONG.
  - SHIFT: `sync_r` = 1 → evaluate, then IDLE.
  - LONG: `sync_r` = 1 → pulse `err_long`, then IDLE. Bits are ignored while in LONG.
- Evaluation on the SHIFT→IDLE transition:
  - `bit_cnt` < 16 → `err_short`.
  - Otherwise, pad bits not zero → `err_pad`.
  - Otherwise → `rx_valid`, `rx_data` ← shift[11:4], `frame_cnt` increments.
- At most one of `rx_valid`/`err_*` pulses per frame. Priority: long > short > pad.
- Any `err_*` pulse increments `err_cnt`, which holds at 2^CNT_W−1.
- A frame must begin in IDLE. `sync_r` staying low across the evaluation cycle is impossible by construction, because evaluation happens only once `sync_r` = 1.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, all `err_*` = 0.
  - `frame_cnt` = 0, `err_cnt` = 0.
  - Shift register = 0, `bit_cnt` = 0, FSM = ARM.
  - `din_r` = 0, `sync_r` = 1.
- Latency: let the last bit be on `din` in cycle L, with `dsync_n` high in L+1. Then `rx_valid` or the error pulse is high in cycle L+3.
- Chained with `spi_dac`: `valid` in cycle T gives bits on `din` in cycles T+1..T+16 and `rx_valid` in cycle T+19.
- Counters update in the same cycle their pulse is asserted.
- The minimum gap between frames is 1 high cycle. Back-to-back frames separated by a single high cycle must all be received.
- Reset asserted mid-frame: all outputs return to reset values immediately, with no pulse for the aborted frame.

## Structure
- Package `spi_dac_pkg` holds:
  - `FRAME_BITS` = 16
  - `DATA_MSB` = 11, `DATA_LSB` = 4
  - `PAD_HI_MASK` = 16'hF000, `PAD_LO_MASK` = 16'h000F
  - FSM state enum {ARM, IDLE, SHIFT, LONG}
- The package is shared with any future revision of `spi_dac`.
- One sub-module, `sat_counter` (parameter width, inputs inc/clear, saturating), is used for `err_cnt`. `frame_cnt` is a plain wrapping counter inline.

## Test plan
- `spi_dac` loopback, `data_spi` = 8'hA5 at T → `rx_valid` at T+19, `rx_data` = 8'hA5, `frame_cnt` = 1, no errors.
- Four back-to-back `spi_dac` frames (8'h00, 8'hFF, 8'h3C, 8'hC3), each issued 17 cycles after the previous one → four `rx_valid` pulses with matching data, `frame_cnt` = 4.
- `spi_dac` `valid` re-asserted 8 cycles into a frame → single `err_long`, `err_cnt` = 1, `rx_data` unchanged. The restarted frame is not reported as good.
- Hand-driven 10-bit low pulse on `dsync_n` → `err_short`. Hand-driven 16-bit frame 16'h1A50 → `err_pad`, no `rx_valid`.
- `rst` pulsed at bit 6 of a frame → outputs to reset values. The remainder of that frame is discarded in ARM; the next full frame 8'h5A is received normally.
- Force `err_cnt` near 2^CNT_W−1 (CNT_W = 4, 17 short frames) → `err_cnt` holds at 4'hF.
